// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: single-issue fetch / issue / branch-resolve sequencer with NZCV flags and retire counter.
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/addr/ack/rdata  instruction memory fetch handshake (addr = current PC)
//   instr_out/valid/ready    held instruction handed to execute
//   ctl_valid + control bits execute completion, branch/flag controls, ALU zero and NZCV
//   flags, retire_count      architectural NZCV and retired-instruction count
module fetch_branch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        ctl_valid,
    input  logic        UncondBranch,
    input  logic        ZeroBranch,
    input  logic        FlagBranch,
    input  logic        FlagWrite,
    input  logic        alu_zero,
    input  logic [3:0]  alu_flags,
    output logic [3:0]  flags,
    output logic [31:0] retire_count
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, EXEC} stateT;
    stateT state;
    logic [63:0] pc, brOffset, condOffset, nextPc;
    logic condBase, condTrue, taken;
    logic n, z, c, v;
    assign imem_addr = pc;
    assign {n, z, c, v} = flags;
    assign brOffset = {{36{instr_out[25]}}, instr_out[25:0], 2'b00};
    assign condOffset = {{43{instr_out[23]}}, instr_out[23:5], 2'b00};
    // Condition codes come in true/inverted pairs: bits [3:1] pick the test, bit 0 inverts it, 111x is always.
    always_comb begin
        case (instr_out[3:1])
            3'b000:  condBase = z;
            3'b001:  condBase = c;
            3'b010:  condBase = n;
            3'b011:  condBase = v;
            3'b100:  condBase = c & ~z;
            3'b101:  condBase = n == v;
            3'b110:  condBase = ~z & (n == v);
            default: condBase = 1'b1;
        endcase
        condTrue = (instr_out[3:1] == 3'b111) ? 1'b1 : condBase ^ instr_out[0];
    end
    // Highest-priority branch bit alone decides whether the branch is taken.
    assign taken = UncondBranch ? 1'b1 : ZeroBranch ? alu_zero : FlagBranch & condTrue;
    assign nextPc = pc + (taken ? (UncondBranch ? brOffset : condOffset) : 64'd4);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instr_out    <= '0;
            flags        <= '0;
            retire_count <= '0;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    state       <= ISSUE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b1;
                    instr_out   <= imem_rdata;
                end
                ISSUE: if (instr_ready) begin
                    state       <= EXEC;
                    instr_valid <= 1'b0;
                end
                EXEC: if (ctl_valid) begin
                    state        <= FETCH;
                    imem_req     <= 1'b1;
                    pc           <= nextPc;
                    retire_count <= retire_count + 32'd1;
                    if (FlagWrite) flags <= alu_flags;
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_branch_unit.sv
// tb_fetch_branch_unit: table-driven, randomized and reset-corner checks of fetch_branch_unit against a behavioural model.
module tb_fetch_branch_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0, instr_out, retire_count;
    logic        ctl_valid = 1'b0, UncondBranch = 1'b0, ZeroBranch = 1'b0, FlagBranch = 1'b0, FlagWrite = 1'b0, alu_zero = 1'b0;
    logic [3:0]  alu_flags = '0, flags;
    int checks = 0, errors = 0;
    logic [63:0] modelPc = '0;
    logic [3:0]  modelFlags = '0;
    logic [31:0] modelCount = '0;

    fetch_branch_unit #(.RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ctl_valid(ctl_valid), .UncondBranch(UncondBranch), .ZeroBranch(ZeroBranch), .FlagBranch(FlagBranch),
        .FlagWrite(FlagWrite), .alu_zero(alu_zero), .alu_flags(alu_flags), .flags(flags), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        u, z, f, fw, az;
        logic [3:0]  af;
        logic [63:0] expPc;
        logic [3:0]  expFlags;
    } vecT;
    vecT tbl[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Architectural branch rule: sign-extended word offsets, NZCV condition table, priority U > Z > F.
    function automatic logic [63:0] refNext(input logic [63:0] pc, input logic [31:0] ins,
                                            input logic u, input logic zb, input logic fb,
                                            input logic az, input logic [3:0] fl);
        logic nf, zf, cf, vf, cond, tk;
        longint off;
        {nf, zf, cf, vf} = fl;
        case (ins[3:0])
            4'd0:  cond = zf;
            4'd1:  cond = !zf;
            4'd2:  cond = cf;
            4'd3:  cond = !cf;
            4'd4:  cond = nf;
            4'd5:  cond = !nf;
            4'd6:  cond = vf;
            4'd7:  cond = !vf;
            4'd8:  cond = cf && !zf;
            4'd9:  cond = !(cf && !zf);
            4'd10: cond = nf == vf;
            4'd11: cond = nf != vf;
            4'd12: cond = !zf && (nf == vf);
            4'd13: cond = !(!zf && (nf == vf));
            default: cond = 1'b1;
        endcase
        if (u) off = longint'($signed(ins[25:0])) * 4;
        else   off = longint'($signed(ins[23:5])) * 4;
        tk = u ? 1'b1 : zb ? az : fb ? cond : 1'b0;
        return tk ? pc + 64'(off) : pc + 64'd4;
    endfunction

    task automatic runInstr(input logic [31:0] ins, input logic u, input logic zb, input logic fb,
                            input logic fw, input logic az, input logic [3:0] af,
                            input int ackDly, input int rdyDly, input int exDly);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_timeout", imem_req, 1);
        if (!imem_req) return;
        chk("fetch_addr", imem_addr, modelPc);
        repeat (ackDly) begin
            @(posedge clk); #1;
            chk("fetch_hold_req", imem_req, 1);
            chk("fetch_hold_addr", imem_addr, modelPc);
        end
        imem_ack = 1'b1; imem_rdata = ins;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = $urandom;
        chk("issue_valid", instr_valid, 1);
        chk("issue_instr", instr_out, ins);
        chk("issue_req", imem_req, 0);
        repeat (rdyDly) begin
            ctl_valid = 1'b1; FlagWrite = 1'b1; alu_flags = 4'($urandom); imem_ack = 1'b1;
            @(posedge clk); #1;
            chk("issue_hold_valid", instr_valid, 1);
            chk("issue_hold_instr", instr_out, ins);
        end
        ctl_valid = 1'b0; FlagWrite = 1'b0; imem_ack = 1'b0; instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("exec_valid", instr_valid, 0);
        chk("exec_req", imem_req, 0);
        repeat (exDly) begin
            imem_ack = 1'b1; instr_ready = 1'b1;
            @(posedge clk); #1;
            chk("exec_wait_req", imem_req, 0);
        end
        imem_ack = 1'b0; instr_ready = 1'b0;
        UncondBranch = u; ZeroBranch = zb; FlagBranch = fb; FlagWrite = fw; alu_zero = az; alu_flags = af;
        ctl_valid = 1'b1;
        @(posedge clk); #1;
        {ctl_valid, UncondBranch, ZeroBranch, FlagBranch, FlagWrite, alu_zero} = '0;
        alu_flags = '0;
        modelPc = refNext(modelPc, ins, u, zb, fb, az, modelFlags);
        if (fw) modelFlags = af;
        modelCount++;
        chk("retire_count", retire_count, modelCount);
        chk("flags", flags, modelFlags);
        chk("next_req", imem_req, 1);
        chk("next_addr", imem_addr, modelPc);
    endtask

    initial begin
        tbl[0]  = '{32'h91000420, 0, 0, 0, 0, 0, 4'hF, 64'h4,  4'h0};
        tbl[1]  = '{32'h91000420, 0, 0, 0, 0, 0, 4'hF, 64'h8,  4'h0};
        tbl[2]  = '{32'h8B020020, 0, 0, 0, 0, 1, 4'hF, 64'hC,  4'h0};
        tbl[3]  = '{32'hD503201F, 0, 0, 0, 0, 0, 4'hF, 64'h10, 4'h0};
        tbl[4]  = '{32'h17FFFFFF, 1, 0, 0, 0, 0, 4'hF, 64'hC,  4'h0};
        tbl[5]  = '{32'h14000005, 1, 0, 0, 0, 0, 4'hF, 64'h20, 4'h0};
        tbl[6]  = '{32'hB4000080, 0, 1, 0, 0, 1, 4'hF, 64'h30, 4'h0};
        tbl[7]  = '{32'h17FFFFFC, 1, 0, 0, 0, 0, 4'hF, 64'h20, 4'h0};
        tbl[8]  = '{32'hB4000080, 0, 1, 0, 0, 0, 4'hF, 64'h24, 4'h0};
        tbl[9]  = '{32'hF1000020, 0, 0, 0, 1, 0, 4'h4, 64'h28, 4'h4};
        tbl[10] = '{32'h17FFFFF8, 1, 0, 0, 0, 0, 4'hF, 64'h8,  4'h4};
        tbl[11] = '{32'h54000040, 0, 0, 1, 0, 0, 4'hF, 64'h10, 4'h4};
        tbl[12] = '{32'h17FFFFFE, 1, 0, 0, 0, 0, 4'hF, 64'h8,  4'h4};
        tbl[13] = '{32'h54000041, 0, 0, 1, 0, 0, 4'hF, 64'hC,  4'h4};
        tbl[14] = '{32'h14000010, 1, 1, 0, 0, 0, 4'hF, 64'h4C, 4'h4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_instr", instr_out, 0);
        chk("rst_flags", flags, 0);
        chk("rst_count", retire_count, 0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            runInstr(tbl[i].instr, tbl[i].u, tbl[i].z, tbl[i].f, tbl[i].fw, tbl[i].az, tbl[i].af, i % 3, (i + 1) % 3, i % 2);
            chk($sformatf("tbl%0d_pc", i), imem_addr, tbl[i].expPc);
            chk($sformatf("tbl%0d_flags", i), flags, tbl[i].expFlags);
            chk($sformatf("tbl%0d_count", i), retire_count, 32'(i + 1));
        end

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ins;
            logic u, zb, fb;
            int kind;
            kind = $urandom_range(0, 3);
            u = 1'b0; zb = 1'b0; fb = 1'b0;
            case (kind)
                0: ins = $urandom;
                1: begin ins = {6'b000101, 26'($urandom)}; u = 1'b1; zb = 1'($urandom); fb = 1'($urandom); end
                2: begin ins = {8'hB4, 19'($urandom), 5'($urandom)}; zb = 1'b1; fb = 1'($urandom); end
                default: begin ins = {8'h54, 19'($urandom), 1'b0, 4'($urandom)}; fb = 1'b1; end
            endcase
            runInstr(ins, u, zb, fb, 1'($urandom), 1'($urandom), 4'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        begin
            int n = 0;
            while (!imem_req && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("mid_req_timeout", imem_req, 1);
            imem_ack = 1'b1; imem_rdata = 32'h8B020020;
            @(posedge clk); #1;
            imem_ack = 1'b0; instr_ready = 1'b1;
            @(posedge clk); #1;
            instr_ready = 1'b0;
            chk("mid_exec_valid", instr_valid, 0);
            ctl_valid = 1'b1; UncondBranch = 1'b1; FlagWrite = 1'b1; alu_flags = 4'hF;
            rst = 1'b1;
            #1;
            chk("mid_rst_valid", instr_valid, 0);
            chk("mid_rst_req", imem_req, 0);
            chk("mid_rst_flags", flags, 0);
            chk("mid_rst_count", retire_count, 0);
            chk("mid_rst_addr", imem_addr, 64'h0);
            chk("mid_rst_instr", instr_out, 0);
            @(posedge clk); #1;
            chk("mid_rst_hold_flags", flags, 0);
            chk("mid_rst_hold_count", retire_count, 0);
            {ctl_valid, UncondBranch, FlagWrite} = '0;
            alu_flags = '0;
            rst = 1'b0;
            modelPc = '0; modelFlags = '0; modelCount = '0;
            runInstr(32'h91000420, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
            chk("post_rst_pc", imem_addr, 64'h4);
            chk("post_rst_count", retire_count, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
